// File: rtl/avr_uart_pkg.sv
// ---------------------------------------------------------------------------
// avr_uart_pkg
//   Definitions shared by the board-side UART peers (receiver now, TX driver
//   later): receiver FSM state encoding, frame data width, default bit period
//   and a pointer-width helper for the receive FIFO.
// ---------------------------------------------------------------------------
package avr_uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // FIFO pointers carry one extra wrap bit so full and empty differ.
    function automatic int uart_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/avr_sync_fifo.sv
// ---------------------------------------------------------------------------
// avr_sync_fifo
//   Single-clock FIFO with a registered head output.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push, din    write request and data (dropped when full unless popping)
//     pop          read request (ignored when empty)
//     dout         current head entry, registered; 0 after reset
//     empty, full  status derived from the wrap-bit pointers
// ---------------------------------------------------------------------------
module avr_sync_fifo
    import avr_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = uart_ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [WIDTH-1:0] r_dout;

    logic             w_wr;
    logic             w_rd;
    logic [PW-1:0]    w_wptr_next;
    logic [PW-1:0]    w_rptr_next;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_rd = pop & ~empty;
    assign w_wr = push & (~full | w_rd);

    assign w_wptr_next = r_wptr + {{(PW-1){1'b0}}, w_wr};
    assign w_rptr_next = r_rptr + {{(PW-1){1'b0}}, w_rd};

    assign dout = r_dout;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_dout <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            // Preload the head of the next cycle; hold when going empty.
            // If the new head is the slot being written now, bypass din.
            if (w_rptr_next != w_wptr_next) begin
                if (w_wr && (r_wptr == w_rptr_next)) begin
                    r_dout <= din;
                end else begin
                    r_dout <= r_mem[w_rptr_next[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/avr_uart_rx_peer.sv
// ---------------------------------------------------------------------------
// avr_uart_rx_peer
//   Board-side 8N1 receiver for the AVR USART TXD pin. Synchronises rxd,
//   samples each bit at its centre, buffers good bytes in a small FIFO and
//   presents them on a valid/ready interface.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     rxd         serial line, idle high, asynchronous to clk
//     rx_data     FIFO head byte (meaningful while rx_valid=1)
//     rx_valid    FIFO not empty
//     rx_ready    consumer takes the head when rx_valid & rx_ready
//     busy        receiver FSM is not idle
//     frame_err   one-cycle pulse: stop bit sampled low
//     overrun     one-cycle pulse: good byte dropped on a full FIFO
// ---------------------------------------------------------------------------
module avr_uart_rx_peer
    import avr_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(UART_DATA_BITS - 1);

    // Synchroniser flops; both reset to the idle line level.
    logic                      r_sync1;
    logic                      r_rxs;

    uart_state_t               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BIT_W-1:0]          r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_busy;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_tick;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxs   <= r_sync1;
        end
    end

    assign w_tick = (r_cnt == '0);
    // A good stop bit pushes the byte on the same edge it is sampled.
    assign w_push = (r_state == ST_STOP) && w_tick && r_rxs;
    assign w_pop  = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            // Only a good frame can push, so this never coincides with frame_err.
            r_overrun   <= w_push && w_full && !w_pop;

            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        r_state <= ST_START;
                        r_cnt   <= HALF_RELOAD;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_rxs) begin
                            // Start bit not low at mid-bit: treat as a glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                            r_cnt   <= FULL_RELOAD;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rxs, r_shift[UART_DATA_BITS-1:1]};
                        r_cnt   <= FULL_RELOAD;
                        if (r_bit == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        if (r_rxs) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_BREAK: begin
                    // Stay here while the line is held low so it cannot retrigger.
                    if (r_rxs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    avr_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_shift),
        .dout  (rx_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rx_valid  = ~w_empty;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_avr_uart_rx_peer.sv
// ---------------------------------------------------------------------------
// tb_avr_uart_rx_peer
//   Self-checking bench for avr_uart_rx_peer (CLKS_PER_BIT=16, FIFO_DEPTH=4).
//   Frames are generated cycle by cycle; a monitor samples outputs 3 time
//   units after each falling edge and records delivered bytes and pulses.
//   Edge numbering: cyc counts rising edges; a frame's t0 is the first
//   rising edge that sees rxd low. The stop sample edge is t0+154, so a
//   pushed byte is visible in the cycle that ends at edge t0+155.
// ---------------------------------------------------------------------------
module tb_avr_uart_rx_peer;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    avr_uart_rx_peer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int   ferr_cnt, ovr_cnt, valid_cnt, busy_cnt, both_cnt;
    int   rise_edge, ovr_edge, ferr_edge;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        #3;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) begin ferr_cnt++; ferr_edge = cyc + 1; end
        if (overrun)   begin ovr_cnt++;  ovr_edge  = cyc + 1; end
        if (frame_err && overrun) both_cnt++;
        if (rx_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (rx_valid && !prev_valid) rise_edge = cyc + 1;
        prev_valid = rx_valid;
    end

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt = 0; ovr_cnt = 0; valid_cnt = 0; busy_cnt = 0;
        rise_edge = -1; ovr_edge = -1; ferr_edge = -1;
    endtask

    function automatic int got(input int i);
        if (i < got_q.size()) return int'(got_q[i]);
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d (0x%0h)", nm, act, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- frame generator ----------------
    // stop_low : number of bit times the stop bit is held low (0 = good frame)
    // pulse_at : -1 leave rx_ready alone, -2 random each cycle,
    //            >=0 rx_ready high only in frame cycle pulse_at
    // abort_at : frame cycle at which rst_n is asserted and sending stops
    int   probe_at = -1;
    logic probe_busy;

    task automatic send_frame(input logic [7:0] d, input int stop_low,
                              input int pulse_at, input int abort_at,
                              output int t0);
        int nbits;
        nbits = 10 + stop_low;
        t0 = -1;
        for (int k = 0; k < nbits * CPB; k++) begin
            int idx;
            @(negedge clk);
            if (k == 0) t0 = cyc + 1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                rxd   = 1'b1;
                return;
            end
            idx = k / CPB;
            if (idx == 0)                 rxd = 1'b0;
            else if (idx <= 8)            rxd = d[idx-1];
            else if (idx < 9 + stop_low)  rxd = 1'b0;
            else                          rxd = 1'b1;
            if (pulse_at >= 0)       rx_ready = (k == pulse_at);
            else if (pulse_at == -2) rx_ready = 1'($urandom_range(0, 1));
            if (k == probe_at) begin
                #3;
                probe_busy = busy;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    // Reference model for the random phase: ordered queue of good bytes.
    logic [7:0] exp_q[$];
    int         exp_ferr;

    initial begin
        int t0;
        int t5;

        tbl[0] = '{8'hA5, 0,  1, 0};
        tbl[1] = '{8'h00, 0,  1, 0};
        tbl[2] = '{8'hFF, 0,  1, 0};
        tbl[3] = '{8'h3C, 40, 0, 1};
        tbl[4] = '{8'h81, 1,  0, 1};
        tbl[5] = '{8'h5A, 0,  1, 0};

        clear_mon();
        both_cnt = 0;

        // Reset state
        wait_cyc(3);
        #3;
        chk("reset rx_valid",  int'(rx_valid),  0);
        chk("reset rx_data",   int'(rx_data),   0);
        chk("reset busy",      int'(busy),      0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset overrun",   int'(overrun),   0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);

        // Table-driven frames with rx_ready held high
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            rx_ready = 1'b1;
            probe_at = (i == 3) ? (49 * CPB - 1) : -1;
            send_frame(tbl[i].data, tbl[i].stop_low, -1, -1, t0);
            wait_cyc(4);
            chk($sformatf("tbl%0d pushed", i), got_q.size(), tbl[i].exp_push);
            chk($sformatf("tbl%0d data", i), got(0),
                tbl[i].exp_push != 0 ? int'(tbl[i].data) : -1);
            chk($sformatf("tbl%0d frame_err", i), ferr_cnt, tbl[i].exp_ferr);
            chk($sformatf("tbl%0d overrun", i), ovr_cnt, 0);
            if (i == 0) begin
                chk("A5 rx_valid rise edge", rise_edge - t0, 155);
                chk("A5 rx_valid cycles", valid_cnt, 1);
            end
            if (i == 3) begin
                chk("break busy before line high", int'(probe_busy), 1);
                chk("break busy after line high", int'(busy), 0);
                chk("break frame_err edge", ferr_edge - t0, 155);
            end
        end
        probe_at = -1;

        // Start glitch: 4 cycles low on an idle line
        clear_mon();
        @(negedge clk);
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(40);
        chk("glitch busy cycles", busy_cnt, 8);
        chk("glitch pushed", got_q.size(), 0);
        chk("glitch rx_valid", int'(rx_valid), 0);
        chk("glitch frame_err", ferr_cnt, 0);

        // Five back-to-back frames with no consumer: fifth overruns
        clear_mon();
        rx_ready = 1'b0;
        t5 = 0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 0, -1, -1, t0);
            if (v == 5) t5 = t0;
        end
        wait_cyc(4);
        #3;
        chk("ovr count", ovr_cnt, 1);
        chk("ovr edge", ovr_edge - t5, 155);
        chk("ovr rx_valid held", int'(rx_valid), 1);
        chk("ovr head stable", int'(rx_data), 8'h01);
        @(negedge clk);
        rx_ready = 1'b1;
        wait_cyc(8);
        rx_ready = 1'b0;
        chk("drain count", got_q.size(), 4);
        for (int j = 0; j < 4; j++) chk($sformatf("drain byte%0d", j), got(j), j + 1);
        chk("drain empty", int'(rx_valid), 0);

        // Full FIFO with a pop in the stop-sample cycle: no overrun
        clear_mon();
        send_frame(8'h11, 0, -1, -1, t0);
        send_frame(8'h22, 0, -1, -1, t0);
        send_frame(8'h33, 0, -1, -1, t0);
        send_frame(8'h44, 0, -1, -1, t0);
        send_frame(8'h55, 0, 154, -1, t0);
        wait_cyc(4);
        chk("fullpop overrun", ovr_cnt, 0);
        chk("fullpop popped", got(0), 8'h11);
        @(negedge clk);
        rx_ready = 1'b1;
        wait_cyc(8);
        rx_ready = 1'b0;
        chk("fullpop count", got_q.size(), 5);
        for (int j = 1; j < 5; j++) chk($sformatf("fullpop byte%0d", j), got(j), 8'h11 * (j + 1));

        // Reset during the 4th data bit of 0xFF, then a clean 0x5A
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'hFF, 0, -1, 4 * CPB + 8, t0);
        @(negedge clk);
        #3;
        chk("midrst busy",     int'(busy),      0);
        chk("midrst rx_valid", int'(rx_valid),  0);
        chk("midrst rx_data",  int'(rx_data),   0);
        chk("midrst flags",    int'(frame_err) + int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);
        send_frame(8'h5A, 0, -1, -1, t0);
        wait_cyc(4);
        chk("midrst received", got_q.size(), 1);
        chk("midrst byte", got(0), 8'h5A);
        chk("midrst frame_err", ferr_cnt, 0);

        // Random frames, random consumer, against the ordered-queue model
        clear_mon();
        exp_q.delete();
        exp_ferr = 0;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int         sl;
            d  = 8'($urandom);
            sl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(d, sl, -2, -1, t0);
            rx_ready = 1'b1;
            wait_cyc(int'($urandom_range(0, 5)));
            if (sl == 0) exp_q.push_back(d);
            else         exp_ferr++;
        end
        wait_cyc(10);
        chk("rand count", got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            chk($sformatf("rand byte%0d", j), got(j), int'(exp_q[j]));
        chk("rand frame_err", ferr_cnt, exp_ferr);
        chk("rand overrun", ovr_cnt, 0);
        chk("flags never together", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
